// File: rtl/pipelined_csa_adder_pkg.sv
// rtl/pipelined_csa_adder_pkg.sv - shared geometry helpers for the pipelined carry-select adder
package pipelined_csa_adder_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_BLOCK  = 4;
    localparam int DEF_STAGES = 4;

    // Number of carry-select blocks across the operand (NB).
    function automatic int nb_of(input int width, input int block);
        return width / block;
    endfunction

    // Blocks evaluated by each pipeline stage (BLK_PER_STAGE).
    function automatic int blk_per_stage_of(input int width, input int block, input int stages);
        return nb_of(width, block) / stages;
    endfunction

    // Geometry is legal when blocks tile the word and stages tile the blocks.
    function automatic bit cfg_ok(input int width, input int block, input int stages);
        int nb;
        if (block < 1 || width < 1 || stages < 1) return 1'b0;
        if ((width % block) != 0) return 1'b0;
        nb = width / block;
        if (stages > nb) return 1'b0;
        return (nb % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_csa_adder_csa_block.sv
// rtl/pipelined_csa_adder_csa_block.sv - one BLOCK-bit carry-select cell
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;
    logic [BLOCK:0]   c0;
    logic [BLOCK:0]   c1;

    // Two speculative ripple chains, one assuming carry-in 0 and one assuming 1
    always_comb begin
        sum0  = '0;
        sum1  = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i]   = a[i] ^ b[i] ^ c0[i];
            c0[i+1]   = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
            sum1[i]   = a[i] ^ b[i] ^ c1[i];
            c1[i+1]   = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? sum1 : sum0;
    assign cout = cin ? c1[BLOCK] : c0[BLOCK];

endmodule

// File: rtl/pipelined_csa_adder.sv
// rtl/pipelined_csa_adder.sv - pipelined carry-select adder/subtractor with valid/ready flow control
module pipelined_csa_adder
    import pipelined_csa_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NB  = nb_of(WIDTH, BLOCK);
    localparam int BPS = blk_per_stage_of(WIDTH, BLOCK, STAGES);
    localparam int SW  = BPS * BLOCK;
    localparam logic [WIDTH-1:0] ONES = '1;

    if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_check
        $error("pipelined_csa_adder: WIDTH/BLOCK/STAGES do not tile");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] stage_vin;
    logic [STAGES-1:0] stage_cin;
    logic [STAGES-1:0] stage_cout;
    logic [WIDTH-1:0]  r_sum      [0:STAGES-1];
    logic [WIDTH-1:0]  stage_base [0:STAGES-1];
    logic [WIDTH-1:0]  nxt_sum    [0:STAGES-1];
    logic              r_ovf;

    logic [WIDTH-1:0] blk_sum;
    logic [NB-1:0]    blk_cin;
    logic [NB-1:0]    blk_cout;
    logic             msb_carry;

    // The whole pipeline moves only when the output slot is empty or being drained
    assign en       = ~r_v[STAGES-1] | out_ready;
    assign in_ready = en;

    // Subtraction is a + ~b + 1; a borrow-in removes that +1
    assign b_eff = b ^ {WIDTH{sub}};
    assign c_eff = cin ^ sub;

    if (STAGES > 1) begin : g_ops
        logic [WIDTH-1:0] r_a  [0:STAGES-2];
        logic [WIDTH-1:0] r_b  [0:STAGES-2];
        logic [WIDTH-1:0] op_a [0:STAGES-2];
        logic [WIDTH-1:0] op_b [0:STAGES-2];

        for (genvar j = 0; j < STAGES - 1; j++) begin : g_op_in
            if (j == 0) begin : g_first
                assign op_a[j] = a;
                assign op_b[j] = b_eff;
            end else begin : g_next
                assign op_a[j] = r_a[j-1];
                assign op_b[j] = r_b[j-1];
            end
        end

        // Operand skew registers: the not-yet-added upper bits travel with the beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < STAGES - 1; j++) begin
                    r_a[j] <= '0;
                    r_b[j] <= '0;
                end
            end else if (en) begin
                for (int j = 0; j < STAGES - 1; j++) begin
                    if (stage_vin[j]) begin
                        r_a[j] <= op_a[j];
                        r_b[j] <= op_b[j];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << (k * SW);

        if (k == 0) begin : g_head
            assign stage_vin[k]  = in_valid;
            assign stage_cin[k]  = c_eff;
            assign stage_base[k] = '0;
        end else begin : g_tail
            assign stage_vin[k]  = r_v[k-1];
            assign stage_cin[k]  = r_c[k-1];
            assign stage_base[k] = r_sum[k-1];
        end

        assign stage_cout[k] = blk_cout[(k+1)*BPS-1];
        assign nxt_sum[k]    = (stage_base[k] & ~MASK) | (blk_sum & MASK);

        for (genvar j = 0; j < BPS; j++) begin : g_blk
            localparam int IDX = k * BPS + j;
            localparam int LO  = IDX * BLOCK;

            logic [BLOCK-1:0] ba;
            logic [BLOCK-1:0] bb;

            if (k == 0) begin : g_port
                assign ba = a[LO +: BLOCK];
                assign bb = b_eff[LO +: BLOCK];
            end else begin : g_skew
                assign ba = g_ops.r_a[k-1][LO +: BLOCK];
                assign bb = g_ops.r_b[k-1][LO +: BLOCK];
            end

            if (j == 0) begin : g_cin_stage
                assign blk_cin[IDX] = stage_cin[k];
            end else begin : g_cin_chain
                assign blk_cin[IDX] = blk_cout[IDX-1];
            end

            csa_block #(
                .BLOCK(BLOCK)
            ) u_blk (
                .a    (ba),
                .b    (bb),
                .cin  (blk_cin[IDX]),
                .sum  (blk_sum[LO +: BLOCK]),
                .cout (blk_cout[IDX])
            );

            if (IDX == NB - 1) begin : g_msb
                assign msb_carry = ba[BLOCK-1] ^ bb[BLOCK-1] ^ blk_sum[WIDTH-1];
            end
        end
    end

    // Stage valid, partial-sum and carry registers; the last stage is the output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
            end
        end else if (en) begin
            r_v <= stage_vin;
            for (int k = 0; k < STAGES; k++) begin
                if (stage_vin[k]) begin
                    r_sum[k] <= nxt_sum[k];
                    r_c[k]   <= stage_cout[k];
                end
            end
            if (stage_vin[STAGES-1]) begin
                r_ovf <= msb_carry ^ blk_cout[NB-1];
            end
        end
    end

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// tb/tb_pipelined_csa_adder.sv - scoreboard bench for pipelined_csa_adder over three geometries
module tb_pipelined_csa_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(input int cfg, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, nm, act, exp);
    endfunction

    // Arithmetic reference: integer add/sub, modulo 2^w, signed range test for overflow
    function automatic exp_t ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                       input logic cin_in, input logic sub_in);
        exp_t e;
        logic [127:0] m, ua, ub, uc, full;
        logic signed [127:0] sa, sb, sc, sres, lim;
        m  = (128'd1 << w) - 128'd1;
        ua = {64'd0, a_in} & m;
        ub = {64'd0, b_in} & m;
        uc = {127'd0, cin_in};
        if (!sub_in) begin
            full   = ua + ub + uc;
            e.cout = full[w];
        end else begin
            e.cout = (ua >= ub + uc);
            full   = ua - ub - uc;
        end
        e.sum = 64'(full & m);
        sa = ua;
        if (ua[w-1]) sa = sa - (128'sd1 <<< w);
        sb = ub;
        if (ub[w-1]) sb = sb - (128'sd1 <<< w);
        sc   = uc;
        sres = sub_in ? (sa - sb - sc) : (sa + sb + sc);
        lim  = 128'sd1 <<< (w - 1);
        e.ovf       = (sres >= lim) || (sres < -lim);
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    function automatic logic [63:0] rand_op(input int w);
        logic [63:0] r;
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       r = 64'd0;
            1:       r = m;
            2:       r = 64'd1 << (w - 1);
            3:       r = m >> 1;
            default: r = {$urandom(), $urandom()};
        endcase
        return r & m;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 64 : (g == 1) ? 32 : 16;
        localparam int S  = (g == 0) ? 4 : (g == 1) ? 2 : 1;
        localparam int NV = 1000;

        logic         rst_n;
        logic         in_valid, in_ready, cin, sub;
        logic         out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, sum;

        exp_t q[$];
        int   cyc      = 0;
        int   stalls   = 0;
        bit   done     = 1'b0;
        bit   throttle = 1'b0;
        bit   prev_stall = 1'b0;
        logic [W-1:0] prev_sum;
        logic prev_cout, prev_ovf;

        pipelined_csa_adder #(
            .WIDTH  (W),
            .BLOCK  (4),
            .STAGES (S)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf)
        );

        // Monitor: pops expected results on each output transfer, pushes on each input transfer
        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                cyc++;
                if (prev_stall) begin
                    chk(g, "hold_valid", 64'(out_valid), 64'd1);
                    chk(g, "hold_sum", 64'(sum), 64'(prev_sum));
                    chk(g, "hold_flags", {62'd0, cout, ovf}, {62'd0, prev_cout, prev_ovf});
                end
                if (out_valid && !out_ready) begin
                    chk(g, "stall_in_ready", 64'(in_ready), 64'd0);
                    stalls++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk(g, "unexpected_out", 64'(sum), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = q.pop_front();
                        chk(g, "sum", 64'(sum), e.sum);
                        chk(g, "flags", {62'd0, cout, ovf}, {62'd0, e.cout, e.ovf});
                        chk(g, "latency", 64'(cyc - e.acc_cyc - (stalls - e.acc_stall)), 64'(S));
                    end
                end
                if (in_valid && in_ready) begin
                    e = ref_model(W, 64'(a), 64'(b), cin, sub);
                    e.acc_cyc   = cyc;
                    e.acc_stall = stalls;
                    q.push_back(e);
                end
                prev_sum   = sum;
                prev_cout  = cout;
                prev_ovf   = ovf;
                prev_stall = out_valid && !out_ready;
            end
        end

        task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input logic vs);
            in_valid = 1'b1;
            a = va;
            b = vb;
            cin = vc;
            sub = vs;
        endtask

        task automatic wait_accept();
            int  t;
            bit  ok;
            t = 0;
            forever begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                if (throttle) out_ready = 1'($urandom_range(0, 1));
                if (ok) break;
                t++;
                if (t > 200) begin
                    chk(g, "accept_timeout", 64'(t), 64'd0);
                    break;
                end
            end
            in_valid = 1'b0;
        endtask

        task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input logic vs);
            drive(va, vb, vc, vs);
            wait_accept();
        endtask

        task automatic send_rand();
            send(W'(rand_op(W)), W'(rand_op(W)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        endtask

        task automatic drain();
            int t;
            t = 0;
            out_ready = 1'b1;
            while (q.size() != 0 && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk(g, "drain_empty", 64'(q.size()), 64'd0);
        endtask

        initial begin : drv
            logic [W-1:0] ones_w;
            logic [W-1:0] msb_w;
            ones_w = '1;
            msb_w  = ones_w ^ (ones_w >> 1);
            rst_n = 1'b0;
            in_valid = 1'b0;
            a = '0;
            b = '0;
            cin = 1'b0;
            sub = 1'b0;
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            chk(g, "rst_out_valid", 64'(out_valid), 64'd0);
            chk(g, "rst_sum", 64'(sum), 64'd0);
            chk(g, "rst_flags", {62'd0, cout, ovf}, 64'd0);
            chk(g, "rst_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;

            send(ones_w, W'(1), 1'b0, 1'b0);
            send(msb_w, W'(1), 1'b0, 1'b1);
            send(W'(5), W'(7), 1'b0, 1'b1);
            send(W'(10), W'(3), 1'b1, 1'b1);
            send(msb_w ^ ones_w, W'(1), 1'b0, 1'b0);
            send(ones_w, ones_w, 1'b1, 1'b0);
            drain();

            for (int i = 0; i < 8; i++) send_rand();
            drain();

            out_ready = 1'b0;
            for (int i = 0; i < S; i++) send_rand();
            drive(W'(rand_op(W)), W'(rand_op(W)), 1'b0, 1'b1);
            repeat (3) begin
                @(negedge clk);
                chk(g, "bp_in_ready", 64'(in_ready), 64'd0);
                chk(g, "bp_out_valid", 64'(out_valid), 64'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            wait_accept();
            drain();

            for (int i = 0; i < 3; i++) send_rand();
            rst_n = 1'b0;
            #1;
            chk(g, "midrst_out_valid", 64'(out_valid), 64'd0);
            q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            chk(g, "post_rst_in_ready", 64'(in_ready), 64'd1);
            chk(g, "post_rst_out_valid", 64'(out_valid), 64'd0);
            repeat (10) @(posedge clk);
            #1;

            throttle = 1'b1;
            for (int i = 0; i < NV; i++) send_rand();
            throttle = 1'b0;
            drain();
            done = 1'b1;
        end
    end

    initial begin : top_ctl
        fork
            wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
            begin
                #(500_000);
                n_total++;
                $display("FAIL global_timeout: got running, expected all configs done");
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
